// File: rtl/fc_mac_sequencer.sv
// fc_mac_sequencer: control sequencer for one fully-connected layer.
// It buffers an N-element input vector, walks the row-major weight memory one
// operand pair per cycle, and drives the saturating MAC enables with the
// three-stage alignment the MAC expects. It then hands each row's result
// downstream on a valid/ready stream.
//
// state | meaning
// ------+------------------------------------------------------------------
// LOAD  | accept N input elements into x_buf; in_ready high
// ISSUE | one operand pair per cycle (address out, x_buf read registered)
// DRAIN | 3 cycles for the last pair to reach the accumulator
// OUT   | present mac_f; handshake clears the accumulator, next row or LOAD
module fc_mac_sequencer #(
    parameter int M  = 4,
    parameter int N  = 8,
    parameter int W  = 14,
    parameter int AW = (M * N > 1) ? $clog2(M * N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic signed [W-1:0] in_data_i,
    output logic [AW-1:0]       w_addr_o,
    input  logic signed [W-1:0] w_data_i,
    output logic signed [W-1:0] mac_a_o,
    output logic signed [W-1:0] mac_b_o,
    output logic                mac_enable_mult_o,
    output logic                mac_en_pipeline_reg_o,
    output logic                mac_en_acc_o,
    output logic                mac_clear_acc_o,
    input  logic signed [W-1:0] mac_f_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic signed [W-1:0] out_data_o,
    output logic                busy_o
);

    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t              state_q;
    logic [RW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [1:0]          cnt_q;
    logic [AW-1:0]       w_addr_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                s1_q;
    logic                s2_q;
    logic                s3_q;
    logic signed [W-1:0] mac_a_q;
    logic signed [W-1:0] x_buf [N];

    // Sequencing FSM. The weight address is kept as a running counter equal to
    // row*N+col, so no multiplier is needed; it parks on the row's last address
    // through DRAIN/OUT, which keeps it stable under output backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            w_addr_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid_i) begin
                        if (col_q == CW'(N - 1)) begin
                            col_q      <= '0;
                            row_q      <= '0;
                            w_addr_q   <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (col_q == CW'(N - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        col_q    <= col_q + CW'(1);
                        w_addr_q <= w_addr_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == 2'd2) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        col_q       <= '0;
                        if (row_q == RW'(M - 1)) begin
                            row_q      <= '0;
                            w_addr_q   <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_LOAD;
                        end else begin
                            row_q    <= row_q + RW'(1);
                            w_addr_q <= w_addr_q + AW'(1);
                            state_q  <= S_ISSUE;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Input vector storage; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid_i) begin
            x_buf[col_q] <= in_data_i;
        end
    end

    // Enable delay chain and operand-a register, aligned with the 1-cycle weight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            mac_a_q <= '0;
        end else begin
            s1_q <= (state_q == S_ISSUE);
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (state_q == S_ISSUE) begin
                mac_a_q <= x_buf[col_q];
            end
        end
    end

    assign in_ready_o            = in_ready_q;
    assign busy_o                = busy_q;
    assign out_valid_o           = out_valid_q;
    assign out_data_o            = mac_f_i;
    assign w_addr_o              = w_addr_q;
    assign mac_a_o               = mac_a_q;
    assign mac_b_o               = w_data_i;
    assign mac_enable_mult_o     = s1_q;
    assign mac_en_pipeline_reg_o = s2_q;
    assign mac_en_acc_o          = s3_q;
    // Clear lands on the output handshake edge; no enable is active in OUT.
    assign mac_clear_acc_o       = out_valid_q & out_ready_i;

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Testbench for fc_mac_sequencer: models the weight memory and the 14-bit
// saturating MAC, applies a table of directed vectors, and adds hand-written
// sequences for backpressure, mid-operation reset and stream robustness.
module tb_fc_mac_sequencer;

    localparam int M  = 4;
    localparam int N  = 8;
    localparam int W  = 14;
    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic [AW-1:0]       w_addr;
    logic signed [W-1:0] w_data;
    logic signed [W-1:0] mac_a;
    logic signed [W-1:0] mac_b;
    logic                mac_enable_mult;
    logic                mac_en_pipeline_reg;
    logic                mac_en_acc;
    logic                mac_clear_acc;
    logic signed [W-1:0] mac_f;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic                busy;

    always #5 clk = ~clk;

    fc_mac_sequencer #(.M(M), .N(N), .W(W), .AW(AW)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_valid_i            (in_valid),
        .in_ready_o            (in_ready),
        .in_data_i             (in_data),
        .w_addr_o              (w_addr),
        .w_data_i              (w_data),
        .mac_a_o               (mac_a),
        .mac_b_o               (mac_b),
        .mac_enable_mult_o     (mac_enable_mult),
        .mac_en_pipeline_reg_o (mac_en_pipeline_reg),
        .mac_en_acc_o          (mac_en_acc),
        .mac_clear_acc_o       (mac_clear_acc),
        .mac_f_i               (mac_f),
        .out_valid_o           (out_valid),
        .out_ready_i           (out_ready),
        .out_data_o            (out_data),
        .busy_o                (busy)
    );

    // Synchronous weight memory, one-cycle read latency.
    logic signed [W-1:0] wmem [M*N];
    always @(posedge clk) w_data <= wmem[w_addr];

    function automatic logic signed [W-1:0] sat14(input longint v);
        if (v > 8191) return 14'sd8191;
        if (v < -8192) return 14'h2000;
        return W'(v);
    endfunction

    // MAC model: product register, pipeline register, saturating accumulator.
    logic signed [W-1:0] prod_q, pipe_q, acc_q;
    always @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            pipe_q <= '0;
            acc_q  <= '0;
        end else begin
            if (mac_enable_mult) prod_q <= sat14(longint'(mac_a) * longint'(mac_b));
            if (mac_en_pipeline_reg) pipe_q <= prod_q;
            if (mac_clear_acc) acc_q <= '0;
            else if (mac_en_acc) acc_q <= sat14(longint'(acc_q) + longint'(pipe_q));
        end
    end
    assign mac_f = acc_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int xm;
        int wm;
        int e0;
        int e1;
        int e2;
        int e3;
        bit bp;
        bit junk;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;
    int   k;
    logic pm;
    logic pp;
    int   cur_x;
    int   cur_w;
    int   last_hs;

    function automatic int xval(input int xm, input int c);
        case (xm)
            0: return 1;
            1: return 100;
            2: return (c % 2 == 0) ? (c + 1) : -(c + 1);
            default: return 2;
        endcase
    endfunction

    function automatic int wval(input int wm, input int r, input int c);
        case (wm)
            0: return r + 1;
            1: return 100;
            2: return -100;
            3: return r - 2;
            default: return (r % 2 == 1) ? -(c + 1) : (c + 1);
        endcase
    endfunction

    function automatic int exp_of(input vec_t v, input int r);
        case (r)
            0: return v.e0;
            1: return v.e1;
            2: return v.e2;
            default: return v.e3;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Advance one clock, sample 1 ns later, and check enable alignment and operands.
    task automatic tick();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) begin
            k  = 0;
            pm = 1'b0;
            pp = 1'b0;
        end
        chk("pipe_follows_mult", int'(mac_en_pipeline_reg), int'(pm));
        chk("acc_follows_pipe", int'(mac_en_acc), int'(pp));
        if (mac_enable_mult) begin
            chk("mac_a_operand", int'(mac_a), xval(cur_x, k % N));
            chk("mac_b_operand", int'(mac_b), wval(cur_w, k / N, k % N));
            k++;
        end
        pm = mac_enable_mult;
        pp = mac_en_pipeline_reg;
    endtask

    task automatic run_vec(input int vi, input int rst_row);
        vec_t v;
        int   n;
        logic signed [W-1:0] hold_d;
        logic [AW-1:0]       hold_a;
        v = vecs[vi];
        cur_x = v.xm;
        cur_w = v.wm;
        k = 0;
        for (int a = 0; a < M * N; a++) wmem[a] = W'(wval(v.wm, a / N, a % N));
        out_ready = v.junk;
        for (int c = 0; c < N; c++) begin
            if (v.junk) begin
                in_valid = 1'b0;
                n = $urandom_range(0, 2);
                repeat (n) tick();
            end
            in_valid = 1'b1;
            in_data  = W'(xval(v.xm, c));
            #1;
            chk("in_ready_load", int'(in_ready), 1);
            last_hs = cyc;
            tick();
        end
        in_valid = v.junk;
        in_data  = 14'sd777;
        for (int r = 0; r < M; r++) begin
            if (r == rst_row) begin
                n = 0;
                while (int'(w_addr) != r * N + 3 && n < 20) begin
                    tick();
                    n++;
                end
                chk("reach_row_issue", int'(w_addr), r * N + 3);
                reset    = 1'b1;
                in_valid = 1'b0;
                tick();
                reset = 1'b0;
                chk("rst_in_ready", int'(in_ready), 1);
                chk("rst_busy", int'(busy), 0);
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_mult", int'(mac_enable_mult), 0);
                chk("rst_pipe", int'(mac_en_pipeline_reg), 0);
                chk("rst_acc", int'(mac_en_acc), 0);
                chk("rst_clear", int'(mac_clear_acc), 0);
                chk("rst_w_addr", int'(w_addr), 0);
                out_ready = 1'b0;
                return;
            end
            n = 0;
            while (!out_valid && n < 40) begin
                tick();
                n++;
            end
            chk("out_valid_rise", int'(out_valid), 1);
            if (r == 0) chk("first_latency", cyc - last_hs, N + 4);
            if (v.bp && r == 1) begin
                out_ready = 1'b0;
                hold_d = out_data;
                hold_a = w_addr;
                repeat (10) begin
                    tick();
                    chk("bp_valid_hold", int'(out_valid), 1);
                    chk("bp_data_hold", int'(out_data), int'(hold_d));
                    chk("bp_addr_hold", int'(w_addr), int'(hold_a));
                    chk("bp_no_enables", int'({mac_enable_mult, mac_en_pipeline_reg, mac_en_acc, mac_clear_acc}), 0);
                end
            end
            if (r == M - 1) in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            chk("out_data", int'(out_data), exp_of(v, r));
            chk("clear_on_handshake", int'(mac_clear_acc), 1);
            chk("no_acc_with_clear", int'(mac_en_acc), 0);
            tick();
            if (r < M - 1) begin
                chk("next_row_addr", int'(w_addr), (r + 1) * N);
                chk("valid_drop", int'(out_valid), 0);
                out_ready = v.junk;
            end else begin
                chk("back_to_load", int'(in_ready), 1);
                chk("idle_busy", int'(busy), 0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{xm: 0, wm: 0, e0: 8,     e1: 16,    e2: 24,    e3: 32,    bp: 1'b1, junk: 1'b0};
        vecs[1] = '{xm: 1, wm: 1, e0: 8191,  e1: 8191,  e2: 8191,  e3: 8191,  bp: 1'b0, junk: 1'b0};
        vecs[2] = '{xm: 1, wm: 2, e0: -8192, e1: -8192, e2: -8192, e3: -8192, bp: 1'b0, junk: 1'b0};
        vecs[3] = '{xm: 2, wm: 3, e0: 8,     e1: 4,     e2: 0,     e3: -4,    bp: 1'b0, junk: 1'b0};
        vecs[4] = '{xm: 3, wm: 4, e0: 72,    e1: -72,   e2: 72,    e3: -72,   bp: 1'b0, junk: 1'b1};

        k = 0;
        pm = 1'b0;
        pp = 1'b0;
        cur_x = 0;
        cur_w = 0;
        last_hs = 0;
        for (int a = 0; a < M * N; a++) wmem[a] = '0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_enables", int'({mac_enable_mult, mac_en_pipeline_reg, mac_en_acc, mac_clear_acc}), 0);
        chk("reset_w_addr", int'(w_addr), 0);
        chk("reset_mac_a", int'(mac_a), 0);
        reset = 1'b0;
        tick();

        for (int vi = 0; vi < 5; vi++) run_vec(vi, -1);
        run_vec(0, 2);
        run_vec(3, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_mac_sequencer.md
# fc_mac_sequencer

Control sequencer for one fully-connected layer built on the 14-bit saturating MAC datapath. It buffers an N-element input vector from a valid/ready stream and reads row-major weights from a synchronous weight memory. It drives the MAC's operand and enable/clear controls with the pipeline alignment the MAC requires, then emits one saturated dot product per output neuron on a valid/ready output stream.

## Interface
- M, 4, number of output neurons (rows)
- N, 8, input vector length (columns), N ≥ 1
- W, 14, data width, fixed to match the MAC
- AW, $clog2(M*N), weight address width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input element valid
- in_ready  out  1  sequencer accepts input element
- in_data  in  W  signed input element
- w_addr  out  AW  weight memory address, row*N + col; data returns 1 cycle later
- w_data  in  W  signed weight read data
- mac_a  out  W  operand a (input element)
- mac_b  out  W  operand b (weight)
- mac_enable_mult  out  1  MAC multiplier enable
- mac_en_pipeline_reg  out  1  MAC product-register enable
- mac_en_acc  out  1  MAC accumulator enable
- mac_clear_acc  out  1  MAC accumulator clear
- mac_f  in  W  MAC accumulator value
- out_valid  out  1  output neuron value valid
- out_ready  in  1  downstream accepts output
- out_data  out  W  equals mac_f
- busy  out  1  high in any state except LOAD

## Operation
- States: LOAD, ISSUE, DRAIN, OUT.
- LOAD:
  - in_ready=1. Each in_valid&&in_ready writes in_data to x_buf[col] and increments col.
  - The N-th handshake sets col=0 and row=0 and moves to ISSUE.
- ISSUE:
  - One operand pair per cycle, no stalls.
  - w_addr=row*N+col. x_buf[col] is read into a register so it aligns with w_data.
  - col increments each cycle. When col=N-1, moves to DRAIN with counter=0.
- DRAIN: exactly 3 cycles, then OUT.
- OUT:
  - out_valid=1, out_data=mac_f. mac_f is stable because no MAC enables are active.
  - On out_valid&&out_ready: mac_clear_acc=1 for that cycle.
  - If row=M-1, go to LOAD with col=0. Otherwise row++, col=0, go to ISSUE.
- Enable chain: v0=(state==ISSUE), delayed through registers s1, s2, s3.
  - mac_enable_mult=s1, mac_en_pipeline_reg=s2, mac_en_acc=s3.
  - mac_a is the registered x_buf read. mac_b=w_data, passed through combinationally.
- Arithmetic (multiply, saturation to [-8192, 8191], accumulation) is entirely in the MAC. The sequencer does no arithmetic beyond address and counter math.
- in_valid outside LOAD is ignored; in_ready=0.
- out_valid is 0 outside OUT. out_ready outside OUT is ignored.

## Timing
- Reset values:
  - state=LOAD, row=col=0, s1=s2=s3=0.
  - in_ready=1, out_valid=0, busy=0.
  - All mac_* enables and clear are 0. w_addr=0, mac_a=0.
  - x_buf contents are don't-care.
- Operand pair k: address in cycle t, mac_enable_mult in t+1, mac_en_pipeline_reg in t+2, mac_en_acc in t+3. The accumulated value is visible on mac_f in t+4.
- Final input handshake in cycle L:
  - ISSUE runs L+1 … L+N; DRAIN runs L+N+1 … L+N+3.
  - out_valid rises in L+N+4.
- Per-row cost: N + 3 + (cycles waiting for out_ready, minimum 1).
- Rows do not overlap.
- mac_clear_acc takes effect at the handshake edge, at least 3 cycles before the next row's first mac_en_acc. clear and en_acc are never high together.
- Backpressure: while out_ready=0, out_valid and out_data hold, and all enables stay 0.
- Reset mid-operation: takes effect on the next edge regardless of state.
  - Pipeline enables are 0 in the following cycle. Partial results are discarded.
  - The MAC shares the same reset, so its accumulator clears too.
- M=1: after the OUT handshake, return directly to LOAD.
- N=1: ISSUE lasts exactly 1 cycle.

## Test plan
- Basic, M=4 N=8: x all 1, w[r][c]=r+1 -> outputs 8, 16, 24, 32 in order. The first out_valid arrives exactly 12 cycles after the final input handshake.
- Saturation: x all 100, w all 100 -> every product saturates to 8191 and the accumulator saturates. Outputs 8191 ×4. A negated-weight variant gives -8192 ×4.
- Backpressure: hold out_ready=0 for 10 cycles on row 1 -> out_valid stays high, out_data is stable, and no mac enables or w_addr changes occur. Row 2 starts exactly 1 cycle after the handshake.
- Alignment: a scoreboard checks that each mac_en_acc pulse follows the matching ISSUE cycle by exactly 3 cycles and mac_a/mac_b match x_buf[col]/w[row][col]. Alternating-sign data yields the exact signed sums.
- Reset mid-ISSUE of row 2: the cycle after reset shows state LOAD, in_ready=1, and all enables 0. A fresh vector then produces correct outputs with no residue.
- Stream robustness: random in_valid gaps and in_valid asserted during ISSUE/OUT -> only the N elements accepted in LOAD are used. Outputs match the reference dot products.
